// File: rtl/pc_fetch_ctrl.sv
// Byte-wide instruction fetch sequencer: opcode fetch, two-byte jump operands, jump/halt control.
// Build option: define PC_FETCH_JZ_EN to decode opcode[7:6]=2'b10 as a conditional jump on flag_z.
module pc_fetch_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  opcode,
  output logic        opcode_valid,
  output logic        jump_high,
  output logic        jump_low,
  output logic [7:0]  jump_data,
  input  logic [15:0] jump_target,
  input  logic        flag_z,
  output logic [15:0] pc,
  output logic        halted
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam logic [DATA_W-1:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_OP,
    ST_FETCH_HI,
    ST_FETCH_LO,
    ST_JUMP,
    ST_HALT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] opcode_d;
  logic              opcode_valid_d;
  logic              halted_d;
  logic              op_is_jump;
  logic              jump_taken;

  // Opcode classes that carry a two-byte target operand
`ifdef PC_FETCH_JZ_EN
  assign op_is_jump = (mem_rdata[7:6] == 2'b01) || (mem_rdata[7:6] == 2'b10);
  assign jump_taken = (opcode[7:6] == 2'b01) || ((opcode[7:6] == 2'b10) && flag_z);
`else
  logic unused_flag_z;
  assign unused_flag_z = flag_z;
  assign op_is_jump = (mem_rdata[7:6] == 2'b01);
  assign jump_taken = (opcode[7:6] == 2'b01);
`endif

  assign mem_addr  = pc;
  assign jump_data = mem_rdata;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc           <= '0;
      opcode       <= '0;
      opcode_valid <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc           <= pc_d;
      opcode       <= opcode_d;
      opcode_valid <= opcode_valid_d;
      halted       <= halted_d;
    end
  end

  // Next-state, next-register values and combinational strobes
  always_comb begin
    state_d        = state_q;
    pc_d           = pc;
    opcode_d       = opcode;
    opcode_valid_d = 1'b0;
    mem_rd         = 1'b0;
    jump_high      = 1'b0;
    jump_low       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH_OP;
      end
      ST_FETCH_OP: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          opcode_d       = mem_rdata;
          opcode_valid_d = 1'b1;
          pc_d           = ADDR_W'(pc + 16'd1);
          if (mem_rdata == OP_HALT)  state_d = ST_HALT;
          else if (op_is_jump)       state_d = ST_FETCH_HI;
          else if (run)              state_d = ST_FETCH_OP;
          else                       state_d = ST_IDLE;
        end
      end
      ST_FETCH_HI: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          jump_high = 1'b1;
          pc_d      = ADDR_W'(pc + 16'd1);
          state_d   = ST_FETCH_LO;
        end
      end
      ST_FETCH_LO: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          jump_low = 1'b1;
          pc_d     = ADDR_W'(pc + 16'd1);
          state_d  = ST_JUMP;
        end
      end
      ST_JUMP: begin
        if (jump_taken) pc_d = jump_target;
        state_d = run ? ST_FETCH_OP : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset wins over anything the current state would request this cycle
    if (reset) begin
      mem_rd    = 1'b0;
      jump_high = 1'b0;
      jump_low  = 1'b0;
    end

    halted_d = (state_d == ST_HALT);
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: byte memory with programmable wait states,
// attached 16-bit jump register, and queues of expected opcodes and operand strobes.
module tb_pc_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic        jump_high;
  logic        jump_low;
  logic [7:0]  jump_data;
  logic [15:0] jump_target;
  logic        flag_z;
  logic [15:0] pc;
  logic        halted;

  pc_fetch_ctrl dut (
    .clock(clock), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .opcode(opcode), .opcode_valid(opcode_valid),
    .jump_high(jump_high), .jump_low(jump_low), .jump_data(jump_data),
    .jump_target(jump_target), .flag_z(flag_z), .pc(pc), .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory with a wait-state injector on one chosen address
  logic [7:0]  mem [0:65535];
  logic [15:0] stall_addr = 16'h0000;
  int unsigned stall_n = 0;
  int unsigned wait_run = 0;
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = !(mem_rd && (mem_addr == stall_addr) && (wait_run < stall_n));

  always @(posedge clock) begin
    if (mem_rd && (mem_addr == stall_addr)) begin
      if (wait_run < 255) wait_run <= wait_run + 1;
    end else begin
      wait_run <= 0;
    end
  end

  // Jump register loaded by the strobes
  logic [15:0] jreg = 16'h0000;
  assign jump_target = jreg;
  always @(posedge clock) begin
    if (jump_high) jreg[15:8] <= jump_data;
    if (jump_low)  jreg[7:0]  <= jump_data;
  end

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] pc;
  } op_exp_t;

  op_exp_t    exp_op[$];
  logic [7:0] exp_hi[$];
  logic [7:0] exp_lo[$];

  logic        prev_wait = 1'b0;
  logic [15:0] prev_wait_addr = 16'h0000;
  int unsigned wait_total = 0;

  // Scoreboard monitor: pops expectations as the DUT produces them
  always @(negedge clock) begin : mon
    op_exp_t    e;
    logic [7:0] b;
    if (opcode_valid) begin
      if (exp_op.size() == 0) check("op_unexpected", 32'(opcode), 32'h1ff);
      else begin
        e = exp_op.pop_front();
        check("opcode", 32'(opcode), 32'(e.op));
        check("pc_after_op", 32'(pc), 32'(e.pc));
      end
    end
    if (jump_high) begin
      if (exp_hi.size() == 0) check("hi_unexpected", 32'(jump_data), 32'h1ff);
      else begin
        b = exp_hi.pop_front();
        check("jump_high_data", 32'(jump_data), 32'(b));
      end
    end
    if (jump_low) begin
      if (exp_lo.size() == 0) check("lo_unexpected", 32'(jump_data), 32'h1ff);
      else begin
        b = exp_lo.pop_front();
        check("jump_low_data", 32'(jump_data), 32'(b));
      end
    end
    if (jump_high && jump_low) check("both_strobes", 32'(1), 32'(0));
    if (mem_rd && !mem_ready) begin
      wait_total <= wait_total + 1;
      check("wait_strobes", 32'({jump_high, jump_low}), 32'(0));
      if (prev_wait) check("wait_addr_stable", 32'(mem_addr), 32'(prev_wait_addr));
      prev_wait      <= 1'b1;
      prev_wait_addr <= mem_addr;
    end else begin
      prev_wait <= 1'b0;
    end
  end

  task automatic push_op(input logic [7:0] op, input logic [15:0] npc);
    exp_op.push_back({op, npc});
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    run = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_one();
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
  endtask

  // Returns once the controller has sat with no fetch activity for two cycles
  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 100 && quiet < 2; i++) begin
      @(negedge clock);
      if (!mem_rd && !opcode_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 2) check({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_op_left"}, 32'(exp_op.size()), 32'(0));
    check({tag, "_hi_left"}, 32'(exp_hi.size()), 32'(0));
    check({tag, "_lo_left"}, 32'(exp_lo.size()), 32'(0));
  endtask

  initial begin : main
    logic        found;
    int unsigned w0;
    logic [15:0] saved;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset  = 1'b1;
    run    = 1'b0;
    flag_z = 1'b0;

    // Reset state
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_opcode", 32'(opcode), 32'(0));
    check("rst_valid", 32'(opcode_valid), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_mem_rd", 32'(mem_rd), 32'(0));
    check("rst_strobes", 32'({jump_high, jump_low}), 32'(0));
    @(posedge clock);
    #1 reset = 1'b0;

    // Single-byte op with run held: returns to opcode fetch
    mem[0] = 8'h05;
    mem[1] = 8'h05;
    push_op(8'h05, 16'h0001);
    push_op(8'h05, 16'h0002);
    @(negedge clock);
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      found = opcode_valid;
    end
    check("single_seen", 32'(found), 32'(1));
    check("single_refetch_rd", 32'(mem_rd), 32'(1));
    check("single_refetch_addr", 32'(mem_addr), 32'(16'h0001));
    run = 1'b0;
    wait_idle("single");
    check("single_pc", 32'(pc), 32'(16'h0002));
    check_drained("single");

    // Unconditional jump
    do_reset();
    mem[0] = 8'h40; mem[1] = 8'h12; mem[2] = 8'h34;
    push_op(8'h40, 16'h0001);
    exp_hi.push_back(8'h12);
    exp_lo.push_back(8'h34);
    run_one();
    wait_idle("jmp");
    check("jmp_pc", 32'(pc), 32'(16'h1234));
    check("jmp_jreg", 32'(jreg), 32'(16'h1234));
    check_drained("jmp");

    // Conditional jump opcode, flag clear then set
    for (int z = 0; z < 2; z++) begin
      do_reset();
      mem[0] = 8'h80; mem[1] = 8'hAB; mem[2] = 8'hCD;
      flag_z = (z == 1);
      push_op(8'h80, 16'h0001);
`ifdef PC_FETCH_JZ_EN
      exp_hi.push_back(8'hAB);
      exp_lo.push_back(8'hCD);
`endif
      run_one();
      wait_idle("jz");
`ifdef PC_FETCH_JZ_EN
      check("jz_pc", 32'(pc), (z == 1) ? 32'(16'hABCD) : 32'(16'h0003));
`else
      check("jz_pc", 32'(pc), 32'(16'h0001));
`endif
      check_drained("jz");
    end
    flag_z = 1'b0;

    // Three wait states on the high operand byte
    do_reset();
    mem[0] = 8'h40; mem[1] = 8'h56; mem[2] = 8'h78;
    stall_addr = 16'h0001;
    stall_n    = 3;
    w0 = wait_total;
    push_op(8'h40, 16'h0001);
    exp_hi.push_back(8'h56);
    exp_lo.push_back(8'h78);
    run_one();
    wait_idle("wait");
    check("wait_count", 32'(wait_total - w0), 32'(3));
    check("wait_pc", 32'(pc), 32'(16'h5678));
    stall_n = 0;
    check_drained("wait");

    // Jump to FFFF, then a single-byte op wraps pc
    do_reset();
    mem[0] = 8'h40; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[16'hFFFF] = 8'h05;
    push_op(8'h40, 16'h0001);
    exp_hi.push_back(8'hFF);
    exp_lo.push_back(8'hFF);
    run_one();
    wait_idle("wrap_jmp");
    check("wrap_pre_pc", 32'(pc), 32'(16'hFFFF));
    push_op(8'h05, 16'h0000);
    run_one();
    wait_idle("wrap");
    check("wrap_pc", 32'(pc), 32'(16'h0000));
    check_drained("wrap");

    // Halt opcode
    do_reset();
    mem[0] = 8'hFF;
    push_op(8'hFF, 16'h0001);
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      check("halt_halted", 32'(halted), 32'(1));
      check("halt_mem_rd", 32'(mem_rd), 32'(0));
      check("halt_strobes", 32'({jump_high, jump_low}), 32'(0));
      @(negedge clock);
    end
    check("halt_pc", 32'(pc), 32'(16'h0001));
    run = 1'b0;
    check_drained("halt");

    // Reset lands on the cycle the low operand byte would complete
    do_reset();
    mem[0] = 8'h40; mem[1] = 8'hAA; mem[2] = 8'hBB;
    stall_addr = 16'h0002;
    stall_n    = 1;
    push_op(8'h40, 16'h0001);
    exp_hi.push_back(8'hAA);
    run_one();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      found = mem_rd && (mem_addr == 16'h0002) && !mem_ready;
    end
    check("rstlo_reached", 32'(found), 32'(1));
    saved = jreg;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rstlo_no_low", 32'(jump_low), 32'(0));
    check("rstlo_mem_rd", 32'(mem_rd), 32'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rstlo_pc", 32'(pc), 32'(16'h0000));
    check("rstlo_opcode", 32'(opcode), 32'(0));
    check("rstlo_halted", 32'(halted), 32'(0));
    check("rstlo_jreg", 32'(jreg), 32'(saved));
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rstlo_idle_rd", 32'(mem_rd), 32'(0));
    end
    stall_n = 0;
    check_drained("rstlo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: run  in  1  fetch enable, sampled only at instruction boundaries.
REQ-004 SHALL have ports: mem_addr  out  16  byte address of current fetch, equal to pc.
REQ-005 SHALL have ports: mem_rd  out  1  read request, high in FETCH_OP/FETCH_HI/FETCH_LO.
REQ-006 SHALL have ports: mem_rdata  in  8  read data, valid when mem_ready=1.
REQ-007 SHALL have ports: mem_ready  in  1  read completes this cycle; zero or more wait cycles allowed.
REQ-008 SHALL have ports: opcode  out  8  last fetched opcode, registered.
REQ-009 SHALL have ports: opcode_valid  out  1  one-cycle registered pulse after an opcode byte is captured.
REQ-010 SHALL have ports: jump_high  out  1  high-byte load strobe to the 16-bit jump register, combinational.
REQ-011 SHALL have ports: jump_low  out  1  low-byte load strobe to the 16-bit jump register, combinational.
REQ-012 SHALL have ports: jump_data  out  8  byte bus to the jump register, equal to mem_rdata.
REQ-013 SHALL have ports: jump_target  in  16  jump register output.
REQ-014 SHALL have ports: flag_z  in  1  zero flag for conditional jump.
REQ-015 SHALL have ports: pc  out  16  program counter.
REQ-016 SHALL have ports: halted  out  1  high while in HALT.

Function
REQ-017 SHALL implement states IDLE, FETCH_OP, FETCH_HI, FETCH_LO, JUMP, HALT.
REQ-018 SHALL, in IDLE, hold pc and move to FETCH_OP when run=1.
REQ-019 SHALL, in any FETCH state, stay put while mem_ready=0 with mem_rd=1 and mem_addr=pc held.
REQ-020 SHALL, in FETCH_OP with mem_ready=1: opcode<=mem_rdata; opcode_valid<=1 next cycle; pc<=pc+1.
REQ-021 SHALL, from FETCH_OP, go to: HALT if the byte is 8'hFF; FETCH_HI if bits[7:6]=01 (JMP) or 10 (JZ); otherwise FETCH_OP if run=1, else IDLE.
REQ-022 SHALL, in FETCH_HI with mem_ready=1, assert jump_high that cycle, set pc<=pc+1, and go to FETCH_LO.
REQ-023 SHALL, in FETCH_LO with mem_ready=1, assert jump_low that cycle, set pc<=pc+1, and go to JUMP.
REQ-024 SHALL assert jump_high/jump_low only in those cycles, never both, never during wait cycles.
REQ-025 SHALL, in JUMP (one cycle), set pc<=jump_target if taken, else keep pc; taken = JMP, or JZ with flag_z=1 sampled in JUMP.
REQ-026 SHALL leave JUMP to FETCH_OP if run=1, else IDLE.
REQ-027 SHALL add pc modulo 2^16, so 16'hFFFF+1 = 16'h0000 with no flag.
REQ-028 SHALL, if run drops mid-instruction, complete that instruction and then enter IDLE.
REQ-029 SHALL keep HALT until reset, with mem_rd=0, strobes 0, and halted=1.
REQ-030 SHALL keep opcode_valid 0 in all cycles other than the pulse.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, set state=IDLE, pc=16'h0000, opcode=8'h00, opcode_valid=0, halted=0.
REQ-032 SHALL drive mem_rd=0, jump_high=0 and jump_low=0 while reset=1.
REQ-033 SHALL give reset priority over all other events, including a mid-fetch or JUMP-cycle reset, which abandons the instruction.

Configuration
REQ-034 SHALL support macro PC_FETCH_JZ_EN.
REQ-035 SHALL, when PC_FETCH_JZ_EN is defined, decode opcode bits[7:6]=10 as JZ per REQ-021/REQ-025.
REQ-036 SHALL, when PC_FETCH_JZ_EN is undefined, treat bits[7:6]=10 as single-byte (except 8'hFF) and ignore flag_z.

Verification
REQ-037 SHALL verify: reset, run=1, memory {00:8'h05} -> opcode=05, opcode_valid pulse, pc=0001, back to FETCH_OP.
REQ-038 SHALL verify: memory {00:8'h40,01:8'h12,02:8'h34} with the jump register attached -> jump_high with 12, then jump_low with 34, then pc=16'h1234 after JUMP.
REQ-039 SHALL verify: JZ 8'h80,8'hAB,8'hCD, run once with flag_z=0 and once with flag_z=1 -> pc=0003 vs pc=ABCD (JZ_EN defined); pc=0001 after the opcode (undefined).
REQ-040 SHALL verify: 3 wait cycles (mem_ready=0) during FETCH_HI -> mem_addr stable, no strobe until ready.
REQ-041 SHALL verify: pc=16'hFFFF, single-byte op -> pc=16'h0000.
REQ-042 SHALL verify: 8'hFF -> halted=1, mem_rd=0 for 10 cycles; reset mid-FETCH_LO -> pc=0000, IDLE, no jump_low.
